// File: rtl/masked_reg_file.sv
// DEPTH x WIDTH register file: masked writes, valid/ready read buffer, clear engine.
// Define MASKED_REG_FILE_BYPASS_EN to forward a same-edge write into the read.
module masked_reg_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_gnt,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  input  logic             clr,
  output logic             clr_busy
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_last;
  logic [WIDTH-1:0] w_wr_new;
  logic [WIDTH-1:0] w_rd_val;

  assign clr_busy = (r_state == S_CLEAR);
  assign rd_gnt   = !clr_busy && (!r_rd_valid || rd_ready);
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

  assign w_wr_acc = wr_en && !clr_busy;
  assign w_rd_acc = rd_req && rd_gnt;
  assign w_last   = (r_idx == AW'(DEPTH - 1));

  assign w_wr_new = (r_mem[wr_addr] & ~wr_mask)
                  | (wr_data & wr_mask);

`ifdef MASKED_REG_FILE_BYPASS_EN
  assign w_rd_val = (w_wr_acc && (wr_addr == rd_addr))
                  ? w_wr_new : r_mem[rd_addr];
`else
  assign w_rd_val = r_mem[rd_addr];
`endif

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (clr) w_state_nx = S_CLEAR;
      S_CLEAR: if (w_last) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE) begin
        if (clr) r_idx <= '0;
      end else begin
        r_idx <= r_idx + AW'(1);
      end
    end
  end

  // Clear and write never collide: writes are gated off while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clr_busy) begin
      r_mem[r_idx] <= '0;
    end else if (w_wr_acc) begin
      r_mem[wr_addr] <= w_wr_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (w_rd_acc) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_rd_val;
    end else if (r_rd_valid && rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_masked_reg_file.sv
// Self-checking bench for masked_reg_file.
// Reads are scoreboarded against a reference array held by the bench.
module tb_masked_reg_file;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] wr_mask;
  logic       rd_req;
  logic [2:0] rd_addr;
  logic       rd_gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic       clr;
  logic       clr_busy;

  logic [7:0] model [8];
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  int         n_checks;
  int         n_errors;

  masked_reg_file #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .clr      (clr),
    .clr_busy (clr_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected: got %h, none expected", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          n_errors++;
          $display("FAIL rd_data: got %h, expected %h", rd_data, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d,
                          input logic [7:0] m);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mask = m;
    @(negedge clk);
    if (!clr_busy) model[a] = (model[a] & ~m) | (d & m);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a);
    bit done = 1'b0;
    rd_req = 1'b1;
    rd_addr = a;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (rd_gnt) begin
        exp_q.push_back(model[a]);
        done = 1'b1;
      end
      step();
    end
    rd_req = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL rd_accept_timeout: addr %0d got no grant, expected grant", a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (rd_valid !== 1'b0 || clr_busy !== 1'b0 || rd_data !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_state: got v=%b b=%b d=%h, expected 0 0 00",
               rd_valid, clr_busy, rd_data);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    do_read(3'd5);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      n_errors++;
      $display("FAIL rd_latency: got v=%b d=%h, expected 1 00",
               rd_valid, rd_data);
    end
    step();
  endtask

  task automatic test_masked_write();
    do_write(3'd2, 8'ha5, 8'hff);
    do_write(3'd2, 8'ha5, 8'h0f);
    do_write(3'd2, 8'h3c, 8'hf0);
    do_write(3'd2, 8'hff, 8'h00);
    do_read(3'd2);
    step();
  endtask

  task automatic test_hold();
    rd_ready = 1'b0;
    do_read(3'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (rd_gnt !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'h35) begin
        n_errors++;
        $display("FAIL hold: got g=%b v=%b d=%h, expected 0 1 35",
                 rd_gnt, rd_valid, rd_data);
      end
      step();
    end
    rd_ready = 1'b1;
    step();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h35) begin
      n_errors++;
      $display("FAIL hold_release: got v=%b d=%h, expected 0 35",
               rd_valid, rd_data);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] e;
    wr_en = 1'b1;
    wr_addr = 3'd1;
    wr_data = 8'hff;
    wr_mask = 8'hff;
    rd_req = 1'b1;
    rd_addr = 3'd1;
`ifdef MASKED_REG_FILE_BYPASS_EN
    e = 8'hff;
`else
    e = model[1];
`endif
    @(negedge clk);
    n_checks++;
    if (rd_gnt !== 1'b1) begin
      n_errors++;
      $display("FAIL bypass_gnt: got %b, expected 1", rd_gnt);
    end else begin
      exp_q.push_back(e);
    end
    model[1] = 8'hff;
    step();
    wr_en = 1'b0;
    rd_req = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== e) begin
      n_errors++;
      $display("FAIL bypass: got v=%b d=%h, expected 1 %h",
               rd_valid, rd_data, e);
    end
    step();
    do_read(3'd1);
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 4; i < 8; i++) begin
      do_write(3'(i), 8'h10 + 8'(i), 8'hff);
    end
    rd_req = 1'b1;
    for (int i = 4; i < 8; i++) begin
      rd_addr = 3'(i);
      @(negedge clk);
      n_checks++;
      if (rd_gnt !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_gnt: addr %0d got %b, expected 1", i, rd_gnt);
      end else begin
        exp_q.push_back(model[i]);
      end
      step();
      n_checks++;
      if (rd_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_valid: got %b, expected 1", rd_valid);
      end
    end
    rd_req = 1'b0;
    step();
  endtask

  task automatic test_clear();
    int cnt = 0;
    for (int i = 0; i < 8; i++) begin
      do_write(3'(i), 8'hff, 8'hff);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        wr_en = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'h55;
        wr_mask = 8'hff;
      end
      if (i == 5) clr = 1'b1;
      @(negedge clk);
      if (clr_busy) cnt++;
      step();
      wr_en = 1'b0;
      clr = 1'b0;
    end
    n_checks++;
    if (cnt != 8) begin
      n_errors++;
      $display("FAIL clr_busy_len: got %0d, expected 8", cnt);
    end
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    for (int i = 0; i < 8; i++) do_read(3'(i));
    step();
  endtask

  task automatic test_reset_mid();
    do_write(3'd3, 8'h5a, 8'hff);
    rd_ready = 1'b0;
    do_read(3'd3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    @(negedge clk);
    n_checks++;
    if (clr_busy !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'h5a) begin
      n_errors++;
      $display("FAIL clr_pending: got b=%b v=%b d=%h, expected 1 1 5a",
               clr_busy, rd_valid, rd_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || clr_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got v=%b b=%b, expected 0 0",
               rd_valid, clr_busy);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    rd_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    do_read(3'd3);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_mask = '0;
    rd_req = 1'b0;
    rd_addr = '0;
    rd_ready = 1'b1;
    clr = 1'b0;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    test_reset();
    test_masked_write();
    test_hold();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    step();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
